// File: rtl/fpu_dp_subtractor_seq.sv
// Multi-cycle IEEE-754 double-precision subtractor: result = a - b.
// Implemented as an addition with b's sign flipped at capture. Operands are always
// treated as normal numbers (hidden bit 1, no special values), arithmetic truncates,
// and a single flag reports either overflow or underflow.
// Normalization shifts one bit per cycle, so no wide leading-zero detector is needed.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    request; a, b sampled when start=1 in IDLE
//   a, b                     minuend / subtrahend {sign, exp, mantissa}
//   busy                     high in every state except IDLE
//   done                     one-cycle pulse, result valid
//   result                   registered difference, held until next done
//   overflow_underflow_flag  registered alongside result
module fpu_dp_subtractor_seq #(
   parameter int unsigned MANT_W = 52,
   parameter int unsigned EXP_W  = 11
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [MANT_W+EXP_W:0]   a,
   input  logic [MANT_W+EXP_W:0]   b,
   output logic                    busy,
   output logic                    done,
   output logic [MANT_W+EXP_W:0]   result,
   output logic                    overflow_underflow_flag
);

   localparam int unsigned W  = MANT_W + EXP_W + 1;
   localparam int unsigned SW = MANT_W + 2;

   // A right shift of MANT_W+1 or more clears the hidden bit and all mantissa bits.
   localparam logic [EXP_W-1:0] ShiftLim = EXP_W'(MANT_W + 1);
   // Right-normalize from this exponent (or above) reaches the all-ones exponent.
   localparam logic [EXP_W:0]   ExpOvf   = (EXP_W + 1)'((1 << EXP_W) - 2);
   // Left-normalize from this exponent (or below) reaches zero.
   localparam logic [EXP_W:0]   ExpUnf   = (EXP_W + 1)'(1);

   typedef enum logic [2:0] {StIdle, StAlign, StAddsub, StNorm, StDone} state_e;

   state_e             state_q, state_d;
   logic [W-1:0]       op_a_q, op_a_d;
   logic [W-1:0]       op_b_q, op_b_d;
   logic [MANT_W:0]    big_q, big_d;
   logic [MANT_W:0]    small_q, small_d;
   logic               sign_q, sign_d;
   logic               eff_sub_q, eff_sub_d;
   logic [EXP_W:0]     exp_q, exp_d;
   logic [SW-1:0]      sum_q, sum_d;
   logic [W-1:0]       result_q, result_d;
   logic               flag_q, flag_d;

   // Alignment datapath, only meaningful while in ALIGN.
   logic [EXP_W-1:0]   exp_a, exp_b, exp_diff;
   logic [MANT_W:0]    man_a, man_b, small_shifted;
   logic               a_big;
   logic [SW-1:0]      sum_add, sum_sub;

   assign exp_a = op_a_q[W-2 -: EXP_W];
   assign exp_b = op_b_q[W-2 -: EXP_W];
   assign man_a = {1'b1, op_a_q[MANT_W-1:0]};
   assign man_b = {1'b1, op_b_q[MANT_W-1:0]};

   // Full tie keeps operand a as the larger one.
   assign a_big    = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
   assign exp_diff = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
   assign small_shifted = (exp_diff >= ShiftLim) ? '0 : ((a_big ? man_b : man_a) >> exp_diff);

   // big >= small by construction, so the subtraction never goes negative.
   assign sum_add = {1'b0, big_q} + {1'b0, small_q};
   assign sum_sub = {1'b0, big_q} - {1'b0, small_q};

   always_comb begin
      state_d   = state_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      big_d     = big_q;
      small_d   = small_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      exp_d     = exp_q;
      sum_d     = sum_q;
      result_d  = result_q;
      flag_d    = flag_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               op_a_d  = a;
               op_b_d  = {~b[W-1], b[W-2:0]};
               state_d = StAlign;
            end
         end

         StAlign: begin
            big_d     = a_big ? man_a : man_b;
            small_d   = small_shifted;
            sign_d    = a_big ? op_a_q[W-1] : op_b_q[W-1];
            eff_sub_d = op_a_q[W-1] ^ op_b_q[W-1];
            exp_d     = {1'b0, (a_big ? exp_a : exp_b)};
            state_d   = StAddsub;
         end

         StAddsub: begin
            sum_d   = eff_sub_q ? sum_sub : sum_add;
            state_d = StNorm;
         end

         StNorm: begin
            if (sum_q == '0) begin
               result_d = '0;
               flag_d   = 1'b0;
               state_d  = StDone;
            end else if (sum_q[SW-1]) begin
               if (exp_q >= ExpOvf) begin
                  result_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                  flag_d   = 1'b1;
                  state_d  = StDone;
               end else begin
                  sum_d = sum_q >> 1;
                  exp_d = exp_q + 1'b1;
               end
            end else if (!sum_q[MANT_W]) begin
               if (exp_q <= ExpUnf) begin
                  result_d = {sign_q, {(W-1){1'b0}}};
                  flag_d   = 1'b1;
                  state_d  = StDone;
               end else begin
                  sum_d = sum_q << 1;
                  exp_d = exp_q - 1'b1;
               end
            end else begin
               result_d = {sign_q, exp_q[EXP_W-1:0], sum_q[MANT_W-1:0]};
               flag_d   = 1'b0;
               state_d  = StDone;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         op_a_q    <= '0;
         op_b_q    <= '0;
         big_q     <= '0;
         small_q   <= '0;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         exp_q     <= '0;
         sum_q     <= '0;
         result_q  <= '0;
         flag_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         big_q     <= big_d;
         small_q   <= small_d;
         sign_q    <= sign_d;
         eff_sub_q <= eff_sub_d;
         exp_q     <= exp_d;
         sum_q     <= sum_d;
         result_q  <= result_d;
         flag_q    <= flag_d;
      end
   end

   assign busy                    = (state_q != StIdle);
   assign done                    = (state_q == StDone);
   assign result                  = result_q;
   assign overflow_underflow_flag = flag_q;

endmodule

// File: tb/tb_fpu_dp_subtractor_seq.sv
// Bench for fpu_dp_subtractor_seq: directed vectors, control-path checks and random
// operations against a behavioural model; expected responses are queued at issue time
// and a monitor compares them whenever done is seen.
// Latency is the number of rising edges from the one that samples start through the
// one after which done is high, inclusive.
module tb_fpu_dp_subtractor_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] a, b, result;
   logic        busy, done, flag;

   fpu_dp_subtractor_seq #(.MANT_W(52), .EXP_W(11)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .start                   (start),
      .a                       (a),
      .b                       (b),
      .busy                    (busy),
      .done                    (done),
      .result                  (result),
      .overflow_underflow_flag (flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic        flg;
      int          lat;
      int          s;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, ex);
      end
   endtask

   // Reference: align, add/subtract magnitudes, then normalize by counting leading zeros.
   function automatic void model(input logic [63:0] xa, input logic [63:0] xb,
                                 output logic [63:0] r, output logic f, output int lat);
      logic [63:0] bn;
      logic        sa, sb, sl;
      int          ea, eb, el, d, lz;
      logic [52:0] ma, mb, ml, ms;
      logic [53:0] s;
      bn = {~xb[63], xb[62:0]};
      sa = xa[63];
      sb = bn[63];
      ea = int'(xa[62:52]);
      eb = int'(bn[62:52]);
      ma = {1'b1, xa[51:0]};
      mb = {1'b1, bn[51:0]};
      if (ea > eb || (ea == eb && ma >= mb)) begin
         sl = sa; el = ea; ml = ma; ms = mb; d = ea - eb;
      end else begin
         sl = sb; el = eb; ml = mb; ms = ma; d = eb - ea;
      end
      ms = (d >= 53) ? 53'h0 : (ms >> d);
      s  = (sa == sb) ? ({1'b0, ml} + {1'b0, ms}) : ({1'b0, ml} - {1'b0, ms});
      f  = 1'b0;
      if (s == 54'h0) begin
         r = 64'h0; lat = 4;
      end else if (s[53]) begin
         if (el + 1 >= 2047) begin
            r = {sl, 11'h7FF, 52'h0}; f = 1'b1; lat = 4;
         end else begin
            s = s >> 1; r = {sl, 11'(el + 1), s[51:0]}; lat = 5;
         end
      end else begin
         lz = 0;
         while (!s[52]) begin
            s = s << 1;
            lz++;
         end
         if (lz > 0 && el <= lz) begin
            r = {sl, 63'h0}; f = 1'b1; lat = 3 + ((el > 1) ? el : 1);
         end else begin
            r = {sl, 11'(el - lz), s[51:0]}; lat = 4 + lz;
         end
      end
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy=1 after 200 cycles, required 0");
      end
   endtask

   task automatic issue(input logic [63:0] xa, input logic [63:0] xb,
                        input logic [63:0] er, input logic ef, input int el);
      exp_t e;
      @(negedge clk);
      wait_idle();
      a     = xa;
      b     = xb;
      start = 1'b1;
      e.res = er;
      e.flg = ef;
      e.lat = el;
      e.s   = cyc + 1;
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue_model(input logic [63:0] xa, input logic [63:0] xb);
      logic [63:0] r;
      logic        f;
      int          l;
      model(xa, xb, r, f, l);
      issue(xa, xb, r, f, l);
   endtask

   // Monitor: compare every done against the oldest queued expectation.
   always @(posedge clk) begin
      #1;
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 required no pending operation");
         end else begin
            mon_e = sbq.pop_front();
            chk("result", result, mon_e.res);
            chk("flag", 64'(flag), 64'(mon_e.flg));
            chk("latency", 64'(cyc - mon_e.s + 1), 64'(mon_e.lat));
            chk("busy_in_done", 64'(busy), 64'd1);
         end
      end
   end

   initial begin
      logic [63:0] ra, rb, msk;
      int          mode, ea, eb, k;
      rst   = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #2 rst = 1'b1;
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_result", result, 64'h0);
      chk("reset_flag", 64'(flag), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors with hand-derived expectations.
      issue(64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 4);
      issue(64'h3FF0000000000000, 64'hBFF0000000000000, 64'h4000000000000000, 1'b0, 5);
      issue(64'h3FF8000000000000, 64'h3FF4000000000000, 64'h3FD0000000000000, 1'b0, 6);
      issue(64'h3FF4000000000000, 64'h3FF8000000000000, 64'hBFD0000000000000, 1'b0, 6);
      issue(64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 1'b0, 4);
      issue(64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h7FF0000000000000, 1'b1, 4);

      // start pulses with other operands during ALIGN and NORM must be ignored.
      issue(64'h3FF8000000000000, 64'h3FF4000000000000, 64'h3FD0000000000000, 1'b0, 6);
      a = 64'h4059000000000000; b = 64'hC024000000000000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 64'h7FE0000000000000; b = 64'h0010000000000000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Reset in the middle of NORM aborts and clears outputs immediately.
      issue(64'h3FF8000000000000, 64'h3FF4000000000000, 64'h3FD0000000000000, 1'b0, 6);
      @(negedge clk);
      @(negedge clk);
      chk("busy_in_norm", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      sbq.delete();
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_result", result, 64'h0);
      chk("abort_flag", 64'(flag), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 4);

      // Random operations, biased toward close exponents and near-cancellation.
      for (int i = 0; i < 300; i++) begin
         mode = int'($urandom_range(0, 3));
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         case (mode)
            1: begin
               ea = int'($urandom_range(1, 2046));
               eb = ea + int'($urandom_range(0, 4)) - 2;
               ra[62:52] = 11'(ea);
               rb[62:52] = 11'(eb);
            end
            2: begin
               ea = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 60))
                                                 : int'($urandom_range(1, 2046));
               ra[62:52] = 11'(ea);
               k   = int'($urandom_range(0, 52));
               msk = (64'd1 << k) - 64'd1;
               rb  = ra ^ (rb & msk);
            end
            3: begin
               ea = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2))
                                                 : int'($urandom_range(2044, 2047));
               eb = ea + int'($urandom_range(0, 2)) - 1;
               if (eb < 0) eb = 0;
               if (eb > 2047) eb = 2047;
               ra[62:52] = 11'(ea);
               rb[62:52] = 11'(eb);
               if ($urandom_range(0, 1) == 0) rb[63] = ~ra[63];
            end
            default: ;
         endcase
         issue_model(ra, rb);
      end

      @(negedge clk);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
